// File: rtl/ahb_slave_port_arbiter.sv
// Per-slave AHB arbiter: round-robin grant with burst/lock hold, plus a
// data-phase select that trails the address-phase select by one accepted transfer.
module ahb_slave_port_arbiter #(
  parameter int CHANNEL_NUM = 4,
  parameter int MW          = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [CHANNEL_NUM-1:0] hreq,
  input  logic [CHANNEL_NUM-1:0] hlock,
  input  logic [1:0]             htrans_sel,
  input  logic                   hready,
  output logic [CHANNEL_NUM-1:0] sel_addr,
  output logic [CHANNEL_NUM-1:0] sel_data,
  output logic [MW-1:0]          hmaster,
  output logic                   owner_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CHANNEL_NUM-1:0] sel_addr_q, sel_addr_d;
  logic [CHANNEL_NUM-1:0] sel_data_q, sel_data_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic                   owner_valid_q, owner_valid_d;
  logic [MW-1:0]          rr_ptr_q, rr_ptr_d;

  logic                   owner_locked;
  logic                   arb_point;
  logic                   hi_found, lo_found, win_found;
  logic [MW-1:0]          hi_win, lo_win, win;
  logic [CHANNEL_NUM-1:0] win_onehot;

  // sel_addr is one-hot, so masking hlock with it picks the owner's lock bit
  assign owner_locked = |(hlock & sel_addr_q);

  // SEQ/BUSY (htrans_sel[0]=1) are mid-burst and never re-arbitrate
  assign arb_point = hready &&
                     ((state_q == IDLE) || (!htrans_sel[0] && !owner_locked));

  // Rotating priority split into two ascending scans: indices at or above
  // rr_ptr take precedence, then the wrapped-around indices below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int i = CHANNEL_NUM - 1; i >= 0; i--) begin
      if (hreq[i]) begin
        if (MW'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_win   = MW'(i);
        end else begin
          lo_found = 1'b1;
          lo_win   = MW'(i);
        end
      end
    end
    win_found = hi_found | lo_found;
    win       = hi_found ? hi_win : lo_win;
  end

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      win_onehot[i] = (MW'(i) == win);
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_addr_d    = sel_addr_q;
    sel_data_d    = sel_data_q;
    hmaster_d     = hmaster_q;
    owner_valid_d = owner_valid_q;
    rr_ptr_d      = rr_ptr_q;

    if (hready) begin
      sel_data_d = ((state_q == OWNED) && htrans_sel[1]) ? sel_addr_q : '0;
    end

    if (arb_point) begin
      if (win_found) begin
        state_d       = OWNED;
        sel_addr_d    = win_onehot;
        hmaster_d     = win;
        owner_valid_d = 1'b1;
        rr_ptr_d      = (win == MW'(CHANNEL_NUM - 1)) ? '0 : win + 1'b1;
      end else begin
        state_d       = IDLE;
        sel_addr_d    = '0;
        hmaster_d     = '0;
        owner_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q       <= IDLE;
      sel_addr_q    <= '0;
      sel_data_q    <= '0;
      hmaster_q     <= '0;
      owner_valid_q <= 1'b0;
      rr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      sel_addr_q    <= sel_addr_d;
      sel_data_q    <= sel_data_d;
      hmaster_q     <= hmaster_d;
      owner_valid_q <= owner_valid_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign sel_addr    = sel_addr_q;
  assign sel_data    = sel_data_q;
  assign hmaster     = hmaster_q;
  assign owner_valid = owner_valid_q;

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Directed bench for ahb_slave_port_arbiter with four masters.
module tb_ahb_slave_port_arbiter;

  localparam int N  = 4;
  localparam int MW = 2;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [N-1:0]  hreq;
  logic [N-1:0]  hlock;
  logic [1:0]    htrans_sel;
  logic          hready;
  logic [N-1:0]  sel_addr;
  logic [N-1:0]  sel_data;
  logic [MW-1:0] hmaster;
  logic          owner_valid;

  int n_tests = 0;
  int n_fail  = 0;

  ahb_slave_port_arbiter #(.CHANNEL_NUM(N)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .hreq        (hreq),
    .hlock       (hlock),
    .htrans_sel  (htrans_sel),
    .hready      (hready),
    .sel_addr    (sel_addr),
    .sel_data    (sel_data),
    .hmaster     (hmaster),
    .owner_valid (owner_valid)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] e_addr,
                            input logic [N-1:0] e_data, input logic [MW-1:0] e_master);
    check({tag, ".sel_addr"},    32'(sel_addr),    32'(e_addr));
    check({tag, ".sel_data"},    32'(sel_data),    32'(e_data));
    check({tag, ".hmaster"},     32'(hmaster),     32'(e_master));
    check({tag, ".owner_valid"}, 32'(owner_valid), 32'(|e_addr));
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET     = 1'b1;
    hreq       = '0;
    hlock      = '0;
    htrans_sel = T_IDLE;
    hready     = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  logic [N-1:0]  rr_addr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0]  rr_data [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [MW-1:0] rr_mst  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [N-1:0]  wait_req [3] = '{4'b1100, 4'b0001, 4'b1000};

  initial begin
    // 1: reset state, async reset mid-burst, first grant after release
    do_reset();
    expect_out("reset", '0, '0, '0);
    hreq = 4'b0010;
    tick();
    expect_out("t1.grant", 4'b0010, 4'b0000, 2'd1);
    htrans_sel = T_NONSEQ;
    tick();
    expect_out("t1.nonseq", 4'b0010, 4'b0010, 2'd1);
    htrans_sel = T_SEQ;
    tick();
    expect_out("t1.seq", 4'b0010, 4'b0010, 2'd1);
    #2 HRESET = 1'b1;
    #1 expect_out("t1.async_rst", '0, '0, '0);
    tick();
    HRESET     = 1'b0;
    hreq       = 4'b0110;
    htrans_sel = T_IDLE;
    tick();
    expect_out("t1.after_rst", 4'b0010, 4'b0000, 2'd1);

    // 2: round-robin with all masters requesting
    do_reset();
    hreq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_out($sformatf("t2.rr%0d", k), rr_addr[k], rr_data[k], rr_mst[k]);
      htrans_sel = T_NONSEQ;
    end
    tick();
    expect_out("t2.rr5", 4'b0010, 4'b0001, 2'd1);

    // 3: burst hold; master 1 joins once master 0's burst has started
    do_reset();
    hreq = 4'b0001;
    tick();
    expect_out("t3.grant", 4'b0001, 4'b0000, 2'd0);
    htrans_sel = T_NONSEQ;
    tick();
    expect_out("t3.nonseq", 4'b0001, 4'b0001, 2'd0);
    hreq       = 4'b0011;
    htrans_sel = T_SEQ;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("t3.seq%0d", k), 4'b0001, 4'b0001, 2'd0);
    end
    htrans_sel = T_BUSY;
    tick();
    expect_out("t3.busy", 4'b0001, 4'b0000, 2'd0);
    htrans_sel = T_IDLE;
    tick();
    expect_out("t3.switch", 4'b0010, 4'b0000, 2'd1);

    // 4: wait states freeze everything, rr_ptr included
    htrans_sel = T_NONSEQ;
    hready     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hreq = wait_req[k];
      tick();
      expect_out($sformatf("t4.wait%0d", k), 4'b0010, 4'b0000, 2'd1);
    end
    hready = 1'b1;
    hreq   = 4'b1111;
    tick();
    expect_out("t4.resume", 4'b0100, 4'b0010, 2'd2);

    // 5: lock holds the grant despite competing NONSEQs
    do_reset();
    hreq = 4'b0100;
    tick();
    expect_out("t5.grant", 4'b0100, 4'b0000, 2'd2);
    hlock      = 4'b0100;
    hreq       = 4'b1111;
    htrans_sel = T_NONSEQ;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("t5.locked%0d", k), 4'b0100, 4'b0100, 2'd2);
    end
    hlock = 4'b0000;
    tick();
    expect_out("t5.unlock", 4'b1000, 4'b0100, 2'd3);

    // 6: owner drops its request on its final NONSEQ, then bus goes idle
    do_reset();
    hreq = 4'b0010;
    tick();
    expect_out("t6.grant", 4'b0010, 4'b0000, 2'd1);
    htrans_sel = T_NONSEQ;
    tick();
    expect_out("t6.nonseq", 4'b0010, 4'b0010, 2'd1);
    hreq = 4'b0000;
    tick();
    expect_out("t6.drop", 4'b0000, 4'b0010, 2'd0);
    htrans_sel = T_IDLE;
    tick();
    expect_out("t6.idle", 4'b0000, 4'b0000, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
